// File: rtl/taylor_exp_engine.sv
// Horner-form Taylor evaluator for e^d on an unsigned fixed-point residual; OUT_VALID 2*ORDER cycles after accept.
// Accepts only in IDLE; the result, OVF and OUT_VALID are held in DONE until OUT_READY.
module taylor_exp_engine #(
    parameter int INT_W  = 3,
    parameter int FRAC_W = 23,
    parameter int ORDER  = 3
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [INT_W+FRAC_W-1:0] IN_X,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    output logic [INT_W+FRAC_W-1:0] OUT,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic                    OVF
);
    localparam int W = INT_W + FRAC_W;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_ADD, S_DONE} state_t;

    function automatic logic [W-1:0] coef_f(input int k);
        logic [63:0] fact;
        logic [63:0] num;
        fact = 64'd1;
        for (int i = 2; i <= k; i++) begin
            fact = fact * 64'(i);
        end
        num = 64'd1 << FRAC_W;
        return W'(num / fact);
    endfunction

    // Full 16-entry table so the 4-bit index needs no width adaptation.
    logic [W-1:0] coef_tab [16];
    for (genvar g = 0; g < 16; g++) begin : g_coef
        assign coef_tab[g] = coef_f(g);
    end

    state_t               state_q, state_d;
    logic [W-1:0]         d_q, d_d;
    logic [W-1:0]         acc_q, acc_d;
    logic [W-1:0]         mul_q, mul_d;
    logic [3:0]           k_q, k_d;
    logic                 ovf_q, ovf_d;

    logic [2*W-1:0]        prod;
    logic [2*W-FRAC_W-1:0] prod_sh;
    logic                  mul_ovf;
    logic [W-1:0]          mul_res;
    logic [W:0]            sum;
    logic [W-1:0]          add_res;

    assign prod    = (2*W)'(acc_q) * (2*W)'(d_q);
    assign prod_sh = (2*W-FRAC_W)'(prod >> FRAC_W);
    assign mul_ovf = |prod_sh[2*W-FRAC_W-1:W];
    assign mul_res = mul_ovf ? '1 : prod_sh[W-1:0];
    assign sum     = {1'b0, mul_q} + {1'b0, coef_tab[k_q]};
    assign add_res = sum[W] ? '1 : sum[W-1:0];

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        acc_d   = acc_q;
        mul_d   = mul_q;
        k_d     = k_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (IN_VALID) begin
                    d_d     = IN_X;
                    acc_d   = coef_tab[4'(ORDER)];
                    k_d     = 4'(ORDER - 1);
                    ovf_d   = 1'b0;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                mul_d   = mul_res;
                ovf_d   = ovf_q | mul_ovf;
                state_d = S_ADD;
            end
            S_ADD: begin
                acc_d = add_res;
                ovf_d = ovf_q | sum[W];
                if (k_q == 4'd0) begin
                    state_d = S_DONE;
                end else begin
                    k_d     = k_q - 4'd1;
                    state_d = S_MUL;
                end
            end
            S_DONE: begin
                if (OUT_READY) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            d_q     <= '0;
            acc_q   <= '0;
            mul_q   <= '0;
            k_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            acc_q   <= acc_d;
            mul_q   <= mul_d;
            k_q     <= k_d;
            ovf_q   <= ovf_d;
        end
    end

    assign IN_READY  = (state_q == S_IDLE);
    assign OUT_VALID = (state_q == S_DONE);
    assign OUT       = acc_q;
    assign OVF       = ovf_q;

endmodule

// File: tb/tb_taylor_exp_engine.sv
// Bench for taylor_exp_engine: ORDER=3 and ORDER=1 instances against a plain-arithmetic Taylor model.
module tb_taylor_exp_engine;
    localparam int W      = 26;
    localparam int FRAC_W = 23;
    localparam int ORD0   = 3;
    localparam int ORD1   = 1;
    localparam longint unsigned MAXV = (64'd1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] in_x0 = '0, in_x1 = '0;
    logic         in_vld0 = 1'b0, in_vld1 = 1'b0;
    logic         in_rdy0, in_rdy1;
    logic [W-1:0] out0, out1;
    logic         out_vld0, out_vld1;
    logic         out_rdy0 = 1'b0, out_rdy1 = 1'b0;
    logic         ovf0, ovf1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    taylor_exp_engine #(.INT_W(3), .FRAC_W(FRAC_W), .ORDER(ORD0)) u_dut0 (
        .CLK(clk), .RST(rst), .IN_X(in_x0), .IN_VALID(in_vld0), .IN_READY(in_rdy0),
        .OUT(out0), .OUT_VALID(out_vld0), .OUT_READY(out_rdy0), .OVF(ovf0)
    );

    taylor_exp_engine #(.INT_W(3), .FRAC_W(FRAC_W), .ORDER(ORD1)) u_dut1 (
        .CLK(clk), .RST(rst), .IN_X(in_x1), .IN_VALID(in_vld1), .IN_READY(in_rdy1),
        .OUT(out1), .OUT_VALID(out_vld1), .OUT_READY(out_rdy1), .OVF(ovf1)
    );

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] out;
        logic         ovf;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Sum of d^k/k! evaluated innermost-first, saturating to the format maximum.
    function automatic longint unsigned coef_m(input int k);
        longint unsigned f;
        f = 1;
        for (int i = 2; i <= k; i++) f = f * longint'(i);
        return (64'd1 << FRAC_W) / f;
    endfunction

    function automatic void model(input longint unsigned d, input int order,
                                  output longint unsigned res, output logic ovf);
        longint unsigned acc, q;
        acc = coef_m(order);
        ovf = 1'b0;
        for (int k = order - 1; k >= 0; k--) begin
            q = (acc * d) >> FRAC_W;
            if (q > MAXV) begin q = MAXV; ovf = 1'b1; end
            q = q + coef_m(k);
            if (q > MAXV) begin q = MAXV; ovf = 1'b1; end
            acc = q;
        end
        res = acc;
    endfunction

    // Called at a negedge; returns at the negedge where OUT_VALID is first seen (DUT left in DONE).
    task automatic do_xact(input bit which, input logic [W-1:0] x,
                           output logic [W-1:0] got, output logic got_ovf, output int lat);
        int n;
        n = 0;
        while (!(which ? in_rdy1 : in_rdy0) && n < 50) begin
            @(posedge clk); @(negedge clk); n++;
        end
        if (which) begin in_x1 = x; in_vld1 = 1'b1; end
        else begin in_x0 = x; in_vld0 = 1'b1; end
        @(posedge clk); @(negedge clk);
        in_vld0 = 1'b0;
        in_vld1 = 1'b0;
        lat = 0;
        while (!(which ? out_vld1 : out_vld0) && lat < 100) begin
            @(posedge clk); @(negedge clk); lat++;
        end
        got     = which ? out1 : out0;
        got_ovf = which ? ovf1 : ovf0;
    endtask

    task automatic release_out(input bit which);
        if (which) out_rdy1 = 1'b1; else out_rdy0 = 1'b1;
        @(posedge clk); @(negedge clk);
        out_rdy0 = 1'b0;
        out_rdy1 = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t            vecs[5];
        logic [W-1:0]    got;
        logic            got_ovf;
        int              lat;
        longint unsigned e_out;
        logic            e_ovf;
        int              acc_cyc[$];
        int              gap;
        logic [W-1:0]    d;
        bit              which;

        vecs[0] = '{x: 26'h0000000, out: 26'h0800000, ovf: 1'b0};
        vecs[1] = '{x: 26'h0400000, out: 26'h0D2AAAA, ovf: 1'b0};
        vecs[2] = '{x: 26'h0800000, out: 26'h1555555, ovf: 1'b0};
        vecs[3] = '{x: 26'h3800000, out: 26'h3FFFFFF, ovf: 1'b1};
        vecs[4] = '{x: 26'h0000000, out: 26'h0800000, ovf: 1'b0};

        #12;
        chk("rst_out", out0, 0);
        chk("rst_out_vld", out_vld0, 0);
        chk("rst_ovf", ovf0, 0);
        chk("rst_in_rdy", in_rdy0, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            do_xact(1'b0, vecs[i].x, got, got_ovf, lat);
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(2 * ORD0));
            chk($sformatf("vec%0d_out", i), got, vecs[i].out);
            chk($sformatf("vec%0d_ovf", i), got_ovf, vecs[i].ovf);
            release_out(1'b0);
        end

        // Backpressure: hold DONE for 5 cycles while poking IN_VALID.
        do_xact(1'b0, 26'h0400000, got, got_ovf, lat);
        for (int c = 0; c < 5; c++) begin
            in_x0   = 26'($urandom);
            in_vld0 = 1'b1;
            @(posedge clk); @(negedge clk);
            chk($sformatf("hold%0d_out", c), out0, 26'h0D2AAAA);
            chk($sformatf("hold%0d_vld", c), out_vld0, 1);
            chk($sformatf("hold%0d_ovf", c), ovf0, 0);
            chk($sformatf("hold%0d_in_rdy", c), in_rdy0, 0);
        end
        in_vld0 = 1'b0;
        release_out(1'b0);
        chk("release_in_rdy", in_rdy0, 1);
        chk("release_out_vld", out_vld0, 0);

        // Back-to-back requests with a permanently ready sink.
        in_x0    = '0;
        in_vld0  = 1'b1;
        out_rdy0 = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (in_rdy0) acc_cyc.push_back(c);
            @(posedge clk); @(negedge clk);
        end
        in_vld0 = 1'b0;
        repeat (20) begin @(posedge clk); @(negedge clk); end
        out_rdy0 = 1'b0;
        chk("b2b_two_accepts", 64'(acc_cyc.size() >= 2), 1);
        gap = (acc_cyc.size() >= 2) ? acc_cyc[1] - acc_cyc[0] : 0;
        chk("b2b_gap_ok", 64'(gap >= 2 * ORD0 + 1), 1);

        // Intermediate accumulator after the second ADD.
        in_x0   = 26'h0400000;
        in_vld0 = 1'b1;
        @(posedge clk); @(negedge clk);
        in_vld0 = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("mid_acc2", out0, 26'h0A55555);
        repeat (2) @(posedge clk);
        @(negedge clk);
        release_out(1'b0);

        // Reset during the second MUL state.
        in_x0   = 26'h0400000;
        in_vld0 = 1'b1;
        @(posedge clk); @(negedge clk);
        in_vld0 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("mid_acc1", out0, 26'h04AAAAA);
        #1 rst = 1'b1;
        #1;
        chk("arst_out", out0, 0);
        chk("arst_out_vld", out_vld0, 0);
        chk("arst_ovf", ovf0, 0);
        chk("arst_in_rdy", in_rdy0, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_xact(1'b0, 26'h0400000, got, got_ovf, lat);
        chk("post_rst_out", got, 26'h0D2AAAA);
        chk("post_rst_ovf", got_ovf, 0);
        release_out(1'b0);

        do_xact(1'b1, 26'h0400000, got, got_ovf, lat);
        chk("ord1_lat", 64'(lat), 64'(2 * ORD1));
        chk("ord1_out", got, 26'h0C00000);
        chk("ord1_ovf", got_ovf, 0);
        release_out(1'b1);

        for (int i = 0; i < 40; i++) begin
            which = (i % 4 == 3);
            d = (i % 2 == 1) ? 26'($urandom_range(0, 32'h3FFFFFF)) : 26'($urandom_range(0, 32'h0FFFFFF));
            model(64'(d), which ? ORD1 : ORD0, e_out, e_ovf);
            do_xact(which, d, got, got_ovf, lat);
            chk($sformatf("rnd%0d_out d=0x%0h", i, d), got, e_out);
            chk($sformatf("rnd%0d_ovf d=0x%0h", i, d), got_ovf, e_ovf);
            release_out(which);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/taylor_exp_engine.md
Name: taylor_exp_engine

Overview:
- Self-sequencing Taylor/Horner evaluator: computes e^d ≈ sum_{k=0..ORDER} d^k/k! on an unsigned fixed-point residual d.
- Generalised successor of the fixed 3rd-order stage.
  - Parametrised width and order.
  - Internal coefficient table and FSM replace the external mul/add select and enable lines.
  - Valid/ready handshakes on both sides; saturation with sticky overflow flag.
- Sits after range reduction (d = x - a); its result feeds the final scale-by-e^a multiply.

Parameters:
- INT_W, 3, integer bits of every operand/result.
- FRAC_W, 23, fraction bits; W = INT_W + FRAC_W.
- ORDER, 3, highest Taylor term; legal range 1..12.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- IN_X  input  W  residual d, unsigned Q(INT_W.FRAC_W).
- IN_VALID  input  1  IN_X valid.
- IN_READY  output  1  engine can accept (high only in IDLE).
- OUT  output  W  result, unsigned Q(INT_W.FRAC_W), held while OUT_VALID.
- OUT_VALID  output  1  OUT valid.
- OUT_READY  input  1  downstream accepts OUT.
- OVF  output  1  sticky saturation flag for the current result.

Behaviour:
- Coefficients: coef[k] = floor(2^FRAC_W / k!), constant table computed at elaboration.
  - FRAC_W=23 gives coef0=0x800000, coef1=0x800000, coef2=0x400000, coef3=0x155555.
- Multiply:
  - Full 2W-bit product of acc and d.
  - Result = bits [FRAC_W+W-1 : FRAC_W] (truncation).
  - If any product bit above FRAC_W+W-1 is set: result = all ones and OVF <= 1.
- Add: W+1-bit sum; on carry out, result = all ones and OVF <= 1.
- Registers: d_reg, acc, mul_reg (all W bits); index k (4 bits); state (2 bits).
- FSM states and transitions:
  - IDLE: IN_READY=1. On IN_VALID: d_reg<=IN_X, acc<=coef[ORDER], k<=ORDER-1, OVF<=0, OUT_VALID stays 0 -> MUL.
  - MUL: mul_reg <= sat_trunc(acc*d_reg) -> ADD.
  - ADD: acc <= sat_add(mul_reg, coef[k]).
    - If k==0 -> DONE.
    - Else k<=k-1 -> MUL.
  - DONE: OUT_VALID=1, OUT=acc, OVF valid. On OUT_READY -> IDLE.
    - No same-cycle re-accept; IN_READY rises the following cycle.
- Latency: handshake edge at cycle 0; OUT_VALID high from cycle 2*ORDER. Throughput = one result per 2*ORDER+1 cycles minimum.
- Backpressure: in DONE with OUT_READY=0, OUT, OVF and OUT_VALID are held indefinitely; IN_READY stays 0.
- IN_VALID outside IDLE is ignored; IN_X is only sampled on the accept edge.
- OVF, once set, stays set through the remaining steps. Saturated values propagate (all-ones operand).
- Reset values, asynchronous: state=IDLE, OUT=0, OUT_VALID=0, OVF=0, acc/mul_reg/d_reg/k=0. IN_READY=1 once in IDLE.
  - Reset in any state, including mid-calculation, aborts the computation; no partial result is emitted.
- OUT is driven from acc directly; OUT=0 only after reset. Between results OUT may show intermediate acc values while OUT_VALID=0.

Test Plan:
1. Defaults, IN_X=0x0000000 -> OUT=0x0800000 (1.0), OVF=0, OUT_VALID exactly 6 cycles after the accept edge.
2. IN_X=0x0400000 (0.5) -> OUT=0x0D2AAAA, OVF=0. Intermediate acc after each ADD: 0x4AAAAA, then 0xA55555.
3. IN_X=0x0800000 (1.0) -> OUT=0x1555555, OVF=0.
4. IN_X=0x3800000 (7.0) -> second multiply saturates; OUT=0x3FFFFFF, OVF=1. Next accepted input 0 -> OVF=0, OUT=0x0800000.
5. Backpressure, with separate sub-checks:
   - Hold OUT_READY=0 for 5 cycles in DONE -> OUT, OUT_VALID and OVF stable; IN_READY=0; IN_VALID pulses ignored.
   - OUT_READY=1 -> IDLE next cycle.
   - Two back-to-back inputs -> second accepted no earlier than 2*ORDER+1 cycles after the first.
6. Assert RST asynchronously mid-edge-free during the second MUL state -> OUT_VALID, OUT and OVF go 0 immediately. After release, IN_READY=1 and a new input 0x0400000 yields 0x0D2AAAA. Rerun with ORDER=1 -> IN_X=0x0400000 gives 0x0C00000 after 2 cycles.
